// File: rtl/inst_mem_loadable_if.sv
// inst_mem_loadable_if
//   Bundle of the fetch port and the program-load stream port of the
//   loadable instruction memory.
//   Signal names are written from the memory's point of view:
//   - *_i signals are driven by the fetch stage or the loader.
//   - *_o signals are driven by the memory.
//
//   Fetch port:
//     fetch_en_i, address_i        -> fetch request
//     data_o, data_valid_o, busy_o <- fetched word / stall indication
//
//   Load port:
//     load_start_i, load_valid_i, load_last_i, load_data_i -> program stream
//     load_ready_o, load_done_o, load_count_o              <- stream status
//
//   Modports:
//     master : fetch stage / loader side
//     slave  : memory side
interface inst_mem_loadable_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              fetch_en_i;
  logic [ADDR_W-1:0] address_i;
  logic [DATA_W-1:0] data_o;
  logic              data_valid_o;
  logic              busy_o;
  logic              load_start_i;
  logic              load_valid_i;
  logic              load_last_i;
  logic [DATA_W-1:0] load_data_i;
  logic              load_ready_o;
  logic              load_done_o;
  logic [ADDR_W:0]   load_count_o;

  modport master (
    output fetch_en_i, address_i, load_start_i, load_valid_i, load_last_i, load_data_i,
    input  data_o, data_valid_o, busy_o, load_ready_o, load_done_o, load_count_o
  );

  modport slave (
    input  fetch_en_i, address_i, load_start_i, load_valid_i, load_last_i, load_data_i,
    output data_o, data_valid_o, busy_o, load_ready_o, load_done_o, load_count_o
  );
endinterface

// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable
//   Run-time loadable instruction memory for the processor's fetch stage.
//
//   Operating sequence:
//   - After reset it writes FILL into every entry (CLEAR).
//   - It then serves registered fetches (RUN).
//   - On load_start_i it accepts a program as a valid/ready word stream,
//     written sequentially from address 0 (LOAD).
//
//   Ports:
//     clk_i   : clock, all state changes on the rising edge
//     reset_i : asynchronous active-high reset, forces CLEAR
//     bus     : inst_mem_loadable_if.slave
//               - fetch port: fetch_en_i, address_i, data_o, data_valid_o, busy_o
//               - load port:  load_start_i, load_valid_i, load_last_i,
//                             load_data_i, load_ready_o, load_done_o,
//                             load_count_o
module inst_mem_loadable #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL = DATA_W'(8'hFF)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  inst_mem_loadable_if.slave   bus
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Not reset: CLEAR gives the array defined contents.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  state_t            w_state_next;
  logic [ADDR_W-1:0] w_ptr_next;
  logic [ADDR_W:0]   w_count_next;
  logic              w_done_next;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic              w_fetch;
  logic              w_in_range;

  // Zero-extend so the range check also holds when DEPTH == 2**ADDR_W.
  assign w_in_range = ({1'b0, bus.address_i} < DEPTH_EXT);

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    w_done_next  = 1'b0;
    w_we         = 1'b0;
    w_wdata      = FILL;
    w_fetch      = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (r_ptr == LAST_IDX) begin
          w_state_next = S_RUN;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + 1'b1;
        end
      end
      S_RUN: begin
        // A fetch issued together with load_start_i is still serviced.
        w_fetch = bus.fetch_en_i;
        if (bus.load_start_i) begin
          w_state_next = S_LOAD;
          w_ptr_next   = '0;
          w_count_next = '0;
        end
      end
      S_LOAD: begin
        // load_ready_o is 1 throughout LOAD, so a beat is just load_valid_i.
        if (bus.load_valid_i) begin
          w_we         = 1'b1;
          w_wdata      = bus.load_data_i;
          w_ptr_next   = r_ptr + 1'b1;
          w_count_next = r_count + 1'b1;
          // The last-flag and the top-address conditions collapse into a
          // single finish.
          if (bus.load_last_i || (r_ptr == LAST_IDX)) begin
            w_state_next = S_RUN;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_CLEAR;
        w_ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_data  <= FILL;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
      r_valid <= w_fetch;
      if (w_fetch) begin
        r_data <= w_in_range ? r_mem[bus.address_i] : FILL;
      end
    end
  end

  // Writes land before any read in a later cycle.
  // A fetch in the first RUN cycle after LOAD therefore sees the new program.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[r_ptr] <= w_wdata;
    end
  end

  assign bus.data_o       = r_data;
  assign bus.data_valid_o = r_valid;
  assign bus.busy_o       = (r_state != S_RUN);
  assign bus.load_ready_o = (r_state == S_LOAD);
  assign bus.load_done_o  = r_done;
  assign bus.load_count_o = r_count;

endmodule

// File: tb/tb_inst_mem_loadable.sv
module tb_inst_mem_loadable;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  inst_mem_loadable_if #(.DATA_W(8), .ADDR_W(8)) bus  ();
  inst_mem_loadable_if #(.DATA_W(8), .ADDR_W(8)) bus2 ();

  inst_mem_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .FILL(8'hFF)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  inst_mem_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .FILL(8'hFF)) dut2 (
    .clk_i   (clk),
    .reset_i (rst2),
    .bus     (bus2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.fetch_en_i = 1'b1;
    bus.address_i  = a;
    tick();
    check_val({tag, "_data"}, 32'(bus.data_o), 32'(exp));
    check_val({tag, "_valid"}, 32'(bus.data_valid_o), 32'd1);
    bus.fetch_en_i = 1'b0;
  endtask

  task automatic load_start();
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
  endtask

  task automatic beat(input logic v, input logic l, input logic [7:0] d);
    bus.load_valid_i = v;
    bus.load_last_i  = l;
    bus.load_data_i  = d;
    tick();
    bus.load_valid_i = 1'b0;
    bus.load_last_i  = 1'b0;
  endtask

  task automatic wait_clear(input string tag, input int exp_cycles, input logic sel2);
    int cnt;
    int ndone;
    cnt   = 0;
    ndone = 0;
    while (((sel2 ? bus2.busy_o : bus.busy_o) === 1'b1) && cnt < 400) begin
      tick();
      cnt++;
      if (!sel2 && bus.load_done_o) ndone++;
    end
    check_val({tag, "_clear_cycles"}, 32'(cnt), 32'(exp_cycles));
    check_val({tag, "_no_done"}, 32'(ndone), 32'd0);
  endtask

  initial begin
    bus.fetch_en_i = 0;  bus.address_i = 0;  bus.load_start_i = 0;
    bus.load_valid_i = 0; bus.load_last_i = 0; bus.load_data_i = 0;
    bus2.fetch_en_i = 0; bus2.address_i = 0; bus2.load_start_i = 0;
    bus2.load_valid_i = 0; bus2.load_last_i = 0; bus2.load_data_i = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    tick();
    tick();

    // Reset values
    check_val("rst_data",  32'(bus.data_o),       32'hFF);
    check_val("rst_valid", 32'(bus.data_valid_o), 32'd0);
    check_val("rst_busy",  32'(bus.busy_o),       32'd1);
    check_val("rst_ready", 32'(bus.load_ready_o), 32'd0);
    check_val("rst_done",  32'(bus.load_done_o),  32'd0);
    check_val("rst_count", 32'(bus.load_count_o), 32'd0);

    // Clear: 256 cycles, then fill word everywhere
    rst = 1'b0;
    wait_clear("init", 256, 1'b0);
    fetch_chk("f0",   8'd0,   8'hFF);
    fetch_chk("f17",  8'd17,  8'hFF);
    fetch_chk("f255", 8'd255, 8'hFF);
    tick();
    check_val("idle_valid", 32'(bus.data_valid_o), 32'd0);
    check_val("idle_hold",  32'(bus.data_o),       32'hFF);

    // Load of three words, last on the third
    load_start();
    check_val("l3_ready", 32'(bus.load_ready_o), 32'd1);
    check_val("l3_busy",  32'(bus.busy_o),       32'd1);
    beat(1'b1, 1'b0, 8'hC1);
    beat(1'b1, 1'b0, 8'h90);
    beat(1'b1, 1'b1, 8'h88);
    check_val("l3_done",     32'(bus.load_done_o),  32'd1);
    check_val("l3_ready_lo", 32'(bus.load_ready_o), 32'd0);
    check_val("l3_count",    32'(bus.load_count_o), 32'd3);
    check_val("l3_busy_lo",  32'(bus.busy_o),       32'd0);
    // Fetch in the first RUN cycle returns the new data
    fetch_chk("l3_f0", 8'd0, 8'hC1);
    check_val("l3_done_pulse", 32'(bus.load_done_o), 32'd0);
    fetch_chk("l3_f1", 8'd1, 8'h90);
    fetch_chk("l3_f2", 8'd2, 8'h88);
    fetch_chk("l3_f3", 8'd3, 8'hFF);
    check_val("l3_count_hold", 32'(bus.load_count_o), 32'd3);

    // Valid gaps insert no writes
    load_start();
    check_val("gap_count0", 32'(bus.load_count_o), 32'd0);
    beat(1'b1, 1'b0, 8'h01);
    beat(1'b0, 1'b0, 8'hEE);
    beat(1'b0, 1'b0, 8'hEE);
    check_val("gap_count1", 32'(bus.load_count_o), 32'd1);
    beat(1'b1, 1'b0, 8'h02);
    beat(1'b1, 1'b1, 8'h03);
    check_val("gap_done",  32'(bus.load_done_o),  32'd1);
    check_val("gap_count", 32'(bus.load_count_o), 32'd3);
    fetch_chk("gap_f0", 8'd0, 8'h01);
    fetch_chk("gap_f1", 8'd1, 8'h02);
    fetch_chk("gap_f2", 8'd2, 8'h03);
    fetch_chk("gap_f3", 8'd3, 8'hFF);

    // Full load without last flag: stops after 256 beats
    load_start();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check_val("full_ready_mid", 32'(bus.load_ready_o), 32'd1);
      beat(1'b1, 1'b0, 8'(i));
    end
    check_val("full_done",  32'(bus.load_done_o),  32'd1);
    check_val("full_ready", 32'(bus.load_ready_o), 32'd0);
    check_val("full_count", 32'(bus.load_count_o), 32'd256);
    beat(1'b1, 1'b0, 8'h00);
    check_val("full_257_count", 32'(bus.load_count_o), 32'd256);
    check_val("full_257_done",  32'(bus.load_done_o),  32'd0);
    check_val("full_257_ready", 32'(bus.load_ready_o), 32'd0);
    fetch_chk("full_f255", 8'd255, 8'hFF);
    fetch_chk("full_f10",  8'd10,  8'h0A);
    fetch_chk("full_f0",   8'd0,   8'h00);
    fetch_chk("full_f200", 8'd200, 8'hC8);

    // Reset in the middle of a load
    load_start();
    beat(1'b1, 1'b0, 8'hAA);
    beat(1'b1, 1'b0, 8'hBB);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy",  32'(bus.busy_o),       32'd1);
    check_val("mid_rst_ready", 32'(bus.load_ready_o), 32'd0);
    check_val("mid_rst_count", 32'(bus.load_count_o), 32'd0);
    tick();
    rst = 1'b0;
    wait_clear("mid_rst", 256, 1'b0);
    fetch_chk("mid_rst_f0", 8'd0, 8'hFF);
    fetch_chk("mid_rst_f1", 8'd1, 8'hFF);

    // DEPTH=200 instance
    rst2 = 1'b0;
    wait_clear("d200", 200, 1'b1);
    bus2.fetch_en_i = 1'b1;
    bus2.address_i  = 8'd250;
    tick();
    check_val("d200_f250_data",  32'(bus2.data_o),       32'hFF);
    check_val("d200_f250_valid", 32'(bus2.data_valid_o), 32'd1);
    bus2.address_i    = 8'd5;
    bus2.load_start_i = 1'b1;
    tick();
    bus2.load_start_i = 1'b0;
    check_val("d200_sf_data",  32'(bus2.data_o),       32'hFF);
    check_val("d200_sf_valid", 32'(bus2.data_valid_o), 32'd1);
    check_val("d200_sf_ready", 32'(bus2.load_ready_o), 32'd1);
    bus2.address_i = 8'd0;
    tick();
    check_val("d200_load_valid", 32'(bus2.data_valid_o), 32'd0);
    bus2.fetch_en_i   = 1'b0;
    bus2.load_valid_i = 1'b1;
    bus2.load_last_i  = 1'b1;
    bus2.load_data_i  = 8'h5A;
    tick();
    bus2.load_valid_i = 1'b0;
    bus2.load_last_i  = 1'b0;
    check_val("d200_done",  32'(bus2.load_done_o),  32'd1);
    check_val("d200_count", 32'(bus2.load_count_o), 32'd1);
    bus2.fetch_en_i = 1'b1;
    bus2.address_i  = 8'd0;
    tick();
    bus2.fetch_en_i = 1'b0;
    check_val("d200_f0_data",  32'(bus2.data_o),       32'h5A);
    check_val("d200_f0_valid", 32'(bus2.data_valid_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit guard
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, run-time loadable instruction memory that replaces the fixed combinational instruction ROM in the processor's fetch stage. After reset it fills every entry with a fill word (HALT/default opcode), then serves registered instruction fetches to the PC. On request it accepts a program as a stream of words over a valid/ready port and writes them sequentially from address 0, so programs (multiply, string match, closest pair, ...) can be swapped without re-synthesis.

## Interface
- DATA_W, 8: instruction word width in bits.
- ADDR_W, 8: fetch address width; must satisfy 2**ADDR_W >= DEPTH.
- DEPTH, 256: number of stored instructions.
- FILL, 8'hFF (DATA_W bits): word returned for unwritten/out-of-range entries and written during clear.
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- fetch_en_i  in  1  fetch request for address_i this cycle.
- address_i  in  ADDR_W  fetch address (PC).
- data_o  out  DATA_W  fetched instruction, registered.
- data_valid_o  out  1  data_o holds the result of a fetch accepted in RUN.
- busy_o  out  1  high in CLEAR and LOAD; fetch stage must stall.
- load_start_i  in  1  begin a program load (sampled in RUN only).
- load_valid_i  in  1  load_data_i is valid.
- load_last_i  in  1  current load word is the final one.
- load_data_i  in  DATA_W  program word.
- load_ready_o  out  1  memory accepts a load word this cycle.
- load_done_o  out  1  one-cycle pulse when a load finishes.
- load_count_o  out  ADDR_W+1  words written by the current/most recent load.

## Operation
- States: CLEAR, RUN, LOAD. Reset forces CLEAR.
- CLEAR: write pointer ptr starts at 0; each cycle mem[ptr] <= FILL, ptr++; after writing DEPTH-1 go to RUN. load_* inputs and fetch_en_i ignored.
- RUN: fetch_en_i=1 -> next edge data_o <= (address_i < DEPTH) ? mem[address_i] : FILL, data_valid_o <= 1; fetch_en_i=0 -> data_o holds, data_valid_o <= 0. load_start_i=1 -> go to LOAD, ptr <= 0, load_count_o <= 0; a fetch in the same cycle is still serviced.
- LOAD: load_ready_o=1. Beat = load_valid_i & load_ready_o: mem[ptr] <= load_data_i, ptr++, load_count_o++. Finish on beat with load_last_i=1 or beat writing DEPTH-1 (whichever first; both together -> single finish): load_done_o pulses next cycle, state -> RUN, load_ready_o drops in that same cycle. Entries above last written index keep prior contents (no implicit clear). load_start_i ignored in LOAD. Fetches ignored: data_valid_o=0.
- Memory array is not reset; CLEAR establishes defined contents. Control registers and outputs reset asynchronously.

## Timing
- Reset values: data_o=FILL, data_valid_o=0, busy_o=1, load_ready_o=0, load_done_o=0, load_count_o=0, state CLEAR, ptr=0.
- CLEAR lasts exactly DEPTH cycles after reset release; busy_o falls in cycle DEPTH (first RUN cycle).
- Fetch latency 1 cycle, throughput 1/cycle; address_i may change every cycle.
- Load throughput 1 word/cycle; load_ready_o is combinational from state only (never depends on load_valid_i). Gaps in load_valid_i insert no writes.
- load_done_o asserted exactly one cycle, coincident with first RUN cycle after LOAD; load_count_o stable from then until next load_start_i.
- Fetch in first RUN cycle after LOAD returns newly written data (write-before-read across states).
- reset_i asserted mid-LOAD or mid-CLEAR: immediate return to CLEAR, partial load abandoned, no load_done_o; full clear follows.

## Test plan
- Reset, DEPTH=256: release reset -> busy_o high 256 cycles then low; fetch addresses 0, 17, 255 -> data_o=8'hFF, data_valid_o=1 one cycle after each request.
- Load 3 words 8'hC1, 8'h90, 8'h88 (last on third) -> load_done_o one-cycle pulse, load_count_o=3; fetch 0,1,2,3 -> C1, 90, 88, FF, back-to-back one per cycle.
- Backpressure-free gaps: load_valid_i pattern 1,0,0,1,1(last) with words 01,02,03 -> mem[0..2]=01,02,03, count=3; idle cycles write nothing.
- Full load without load_last_i: 257 valid words (value=index) -> done after 256th beat, load_ready_o low afterwards, 257th ignored, fetch 255 -> 8'hFF (index 255 truncated to DATA_W: 8'hFF) and fetch 10 -> 8'h0A.
- reset_i pulsed after 2 of 5 load words -> no load_done_o, 256-cycle CLEAR, fetch 0 -> 8'hFF.
- DEPTH=200, ADDR_W=8: fetch address 250 -> FILL; load_start_i with fetch_en_i same cycle in RUN -> fetch data returned next cycle, state LOAD, data_valid_o=0 for fetches during LOAD.
